// File: rtl/apb2axi_rd_drain_arb.sv
`default_nettype none
// ============================================================================
// Module   : apb2axi_rd_drain_arb
// Purpose  : Round-robin, burst-locked merge of per-TAG read-data streams into
//            one registered output channel, with a burst-completion pulse.
// Options  : APB2AXI_DRAIN_WDOG_EN adds a stall watchdog that force-closes a
//            burst whose source stays silent for WDOG_CYC cycles.
// Revision : 1.0 - initial release
// ============================================================================
module apb2axi_rd_drain_arb #(
   parameter int TAG_NUM    = 8,
   parameter int APB_DATA_W = 32,
   parameter int WDOG_CYC   = 256
) (
   input  logic                          pclk,
   input  logic                          preset,
   input  logic [TAG_NUM-1:0]            tag_en,
   input  logic [TAG_NUM-1:0]            in_vld,
   input  logic [TAG_NUM*APB_DATA_W-1:0] in_data,
   input  logic [TAG_NUM-1:0]            in_last,
   output logic [TAG_NUM-1:0]            in_rdy,
   output logic                          out_vld,
   output logic [APB_DATA_W-1:0]         out_data,
   output logic                          out_last,
   output logic [$clog2(TAG_NUM)-1:0]    out_tag,
   input  logic                          out_rdy,
   output logic                          done_vld,
   output logic [$clog2(TAG_NUM)-1:0]    done_tag,
   output logic                          done_err
);

   localparam int         c_TW   = $clog2(TAG_NUM);
   localparam logic [0:0] c_IDLE = 1'b0;
   localparam logic [0:0] c_LOCK = 1'b1;

   logic [0:0]            state_q, state_d;
   logic [c_TW-1:0]       grant_tag_q, grant_tag_d;
   logic [c_TW-1:0]       rr_ptr_q, rr_ptr_d;
   logic                  out_vld_q, out_vld_d;
   logic                  out_last_q, out_last_d;
   logic [APB_DATA_W-1:0] out_data_q, out_data_d;
   logic [c_TW-1:0]       out_tag_q, out_tag_d;
   logic                  done_vld_q, done_vld_d;
   logic [c_TW-1:0]       done_tag_q, done_tag_d;
   logic                  done_err_q, done_err_d;

   logic                  w_lock;
   logic                  w_room;
   logic [TAG_NUM-1:0]    w_req;
   logic                  w_pick_vld;
   logic [c_TW-1:0]       w_pick_tag;
   logic [c_TW-1:0]       w_idx;
   logic                  w_sel_vld;
   logic                  w_sel_last;
   logic [APB_DATA_W-1:0] w_sel_data;
   logic                  w_xfer;
   logic                  w_burst_end;
   logic                  w_drain_last;
   logic                  w_wdog_fire;

   assign w_lock       = (state_q == c_LOCK);
   assign w_room       = !out_vld_q || out_rdy;
   assign w_req        = tag_en & in_vld;
   assign w_xfer       = w_lock && w_room && w_sel_vld;
   assign w_burst_end  = w_xfer && w_sel_last;
   assign w_drain_last = out_vld_q && out_rdy && out_last_q;

   // Offsets are walked from the top down so the smallest offset above
   // rr_ptr is the one left standing.
   always_comb begin
      w_pick_vld = 1'b0;
      w_pick_tag = '0;
      w_idx      = '0;
      for (int k = TAG_NUM - 1; k >= 0; k--) begin
         w_idx = rr_ptr_q + c_TW'(k);
         if (w_req[w_idx]) begin
            w_pick_vld = 1'b1;
            w_pick_tag = w_idx;
         end
      end
   end

   always_comb begin
      w_sel_vld  = 1'b0;
      w_sel_last = 1'b0;
      w_sel_data = '0;
      for (int k = 0; k < TAG_NUM; k++) begin
         if (grant_tag_q == c_TW'(k)) begin
            w_sel_vld  = in_vld[k];
            w_sel_last = in_last[k];
            w_sel_data = in_data[k*APB_DATA_W +: APB_DATA_W];
         end
      end
   end

   always_comb begin
      in_rdy = '0;
      if (w_lock) begin
         in_rdy[grant_tag_q] = w_room;
      end
   end

`ifdef APB2AXI_DRAIN_WDOG_EN
   localparam int c_CW = $clog2(WDOG_CYC + 1);

   logic [c_CW-1:0] wdog_cnt_q, wdog_cnt_d;

   // A real completion leaving the output register owns the done slot; the
   // timeout then fires on the following stalled cycle.
   assign w_wdog_fire = w_lock && !w_sel_vld && !w_drain_last &&
                        (wdog_cnt_q >= c_CW'(WDOG_CYC - 1));

   always_comb begin
      wdog_cnt_d = wdog_cnt_q;
      if (!w_lock || w_xfer || w_wdog_fire) begin
         wdog_cnt_d = '0;
      end else if (!w_sel_vld) begin
         wdog_cnt_d = wdog_cnt_q + c_CW'(1);
      end
   end

   always_ff @(posedge pclk or posedge preset) begin
      if (preset) begin
         wdog_cnt_q <= '0;
      end else begin
         wdog_cnt_q <= wdog_cnt_d;
      end
   end
`else
   logic unused_wdog_cyc;

   assign w_wdog_fire     = 1'b0;
   assign unused_wdog_cyc = ^WDOG_CYC;
`endif

   always_comb begin
      state_d     = state_q;
      grant_tag_d = grant_tag_q;
      rr_ptr_d    = rr_ptr_q;
      case (state_q)
         c_IDLE: begin
            if (w_pick_vld) begin
               grant_tag_d = w_pick_tag;
               state_d     = c_LOCK;
            end
         end
         c_LOCK: begin
            if (w_burst_end || w_wdog_fire) begin
               state_d  = c_IDLE;
               rr_ptr_d = grant_tag_q + c_TW'(1);
            end
         end
         default: state_d = c_IDLE;
      endcase
   end

   always_comb begin
      out_vld_d  = out_vld_q;
      out_last_d = out_last_q;
      out_data_d = out_data_q;
      out_tag_d  = out_tag_q;
      if (w_xfer) begin
         out_vld_d  = 1'b1;
         out_last_d = w_sel_last;
         out_data_d = w_sel_data;
         out_tag_d  = grant_tag_q;
      end else if (out_rdy) begin
         out_vld_d = 1'b0;
      end
      done_vld_d = w_drain_last || w_wdog_fire;
      done_err_d = w_wdog_fire;
      done_tag_d = done_tag_q;
      if (w_drain_last) begin
         done_tag_d = out_tag_q;
      end else if (w_wdog_fire) begin
         done_tag_d = grant_tag_q;
      end
   end

   always_ff @(posedge pclk or posedge preset) begin
      if (preset) begin
         state_q     <= c_IDLE;
         grant_tag_q <= '0;
         rr_ptr_q    <= '0;
         out_vld_q   <= 1'b0;
         out_last_q  <= 1'b0;
         out_data_q  <= '0;
         out_tag_q   <= '0;
         done_vld_q  <= 1'b0;
         done_tag_q  <= '0;
         done_err_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         grant_tag_q <= grant_tag_d;
         rr_ptr_q    <= rr_ptr_d;
         out_vld_q   <= out_vld_d;
         out_last_q  <= out_last_d;
         out_data_q  <= out_data_d;
         out_tag_q   <= out_tag_d;
         done_vld_q  <= done_vld_d;
         done_tag_q  <= done_tag_d;
         done_err_q  <= done_err_d;
      end
   end

   assign out_vld  = out_vld_q;
   assign out_last = out_last_q;
   assign out_data = out_data_q;
   assign out_tag  = out_tag_q;
   assign done_vld = done_vld_q;
   assign done_tag = done_tag_q;
   assign done_err = done_err_q;

endmodule
`default_nettype wire

// File: tb/tb_apb2axi_rd_drain_arb.sv
`default_nettype none
// Bench for apb2axi_rd_drain_arb: directed scenarios plus random traffic,
// checked against a transaction-level arbitration and output-order model.
module tb_apb2axi_rd_drain_arb;

   localparam int N     = 8;
   localparam int W     = 32;
   localparam int TW    = 3;
   localparam int WD    = 16;
   localparam int DEPTH = 256;

   logic            pclk = 1'b0;
   logic            preset;
   logic [N-1:0]    tag_en;
   logic [N-1:0]    in_vld;
   logic [N*W-1:0]  in_data;
   logic [N-1:0]    in_last;
   logic [N-1:0]    in_rdy;
   logic            out_vld;
   logic [W-1:0]    out_data;
   logic            out_last;
   logic [TW-1:0]   out_tag;
   logic            out_rdy;
   logic            done_vld;
   logic [TW-1:0]   done_tag;
   logic            done_err;

   apb2axi_rd_drain_arb #(
      .TAG_NUM    (N),
      .APB_DATA_W (W),
      .WDOG_CYC   (WD)
   ) dut (
      .pclk     (pclk),
      .preset   (preset),
      .tag_en   (tag_en),
      .in_vld   (in_vld),
      .in_data  (in_data),
      .in_last  (in_last),
      .in_rdy   (in_rdy),
      .out_vld  (out_vld),
      .out_data (out_data),
      .out_last (out_last),
      .out_tag  (out_tag),
      .out_rdy  (out_rdy),
      .done_vld (done_vld),
      .done_tag (done_tag),
      .done_err (done_err)
   );

   always #5 pclk = ~pclk;

   int n_cmp = 0;
   int n_bad = 0;

   task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, act, exp, $time);
      end
   endtask

   // Per-TAG source streams: {last, data}
   logic [W:0]      src_mem [N][DEPTH];
   int              src_wr [N];
   int              src_rd [N];
   int              seq = 0;

   int              gate_pct = 100;
   int              rdy_mode = 1;   // 0 low, 1 high, 2 random
   logic [N-1:0]    cur_en = '0;

   // Model: expected contents of the output channel and done pulse
   logic [W+TW:0]   exp_q [$];
   logic            e_dv = 1'b0;
   logic            e_de = 1'b0;
   logic [TW-1:0]   e_dt = '0;
   // Model: arbitration at burst granularity
   bit              m_lock = 1'b0;
   int              m_grant = 0;
   int              m_rr = 0;
   int              m_stall = 0;

   logic [TW-1:0]   done_log [$];
   int              acc_cnt [N];
   int              step_no = 0;
   int              pop5_step = -1;
   int              wdog_step = -1;
   logic [TW-1:0]   wdog_tag = '0;

   task automatic add_word(input int t, input logic last);
      logic [W-1:0] d;
      d = {8'(t), 8'(seq), 16'($urandom)};
      seq++;
      src_mem[t][src_wr[t] % DEPTH] = {last, d};
      src_wr[t]++;
   endtask

   task automatic add_burst(input int t, input int len);
      for (int i = 0; i < len; i++) begin
         add_word(t, i == len - 1);
      end
   endtask

   function automatic int rr_pick(input logic [N-1:0] req, input int rr);
      int best;
      int bd;
      best = -1;
      bd   = N;
      for (int t = 0; t < N; t++) begin
         if (req[t] && ((t - rr + N) % N) < bd) begin
            bd   = (t - rr + N) % N;
            best = t;
         end
      end
      return best;
   endfunction

   task automatic chk_zero(input string pfx);
      chk({pfx, "_in_rdy"},   64'(in_rdy),   64'(0));
      chk({pfx, "_out_vld"},  64'(out_vld),  64'(0));
      chk({pfx, "_out_last"}, 64'(out_last), 64'(0));
      chk({pfx, "_out_data"}, 64'(out_data), 64'(0));
      chk({pfx, "_out_tag"},  64'(out_tag),  64'(0));
      chk({pfx, "_done_vld"}, 64'(done_vld), 64'(0));
      chk({pfx, "_done_tag"}, 64'(done_tag), 64'(0));
      chk({pfx, "_done_err"}, 64'(done_err), 64'(0));
   endtask

   task automatic step();
      logic [N-1:0]  exp_rdy;
      logic [N-1:0]  req;
      logic          room;
      logic          pop;
      logic          n_dv;
      logic          n_de;
      logic [TW-1:0] n_dt;
      logic [W:0]    wd;
      logic [W+TW:0] ow;
      @(negedge pclk);
      step_no++;
      for (int t = 0; t < N; t++) begin
         if (src_rd[t] != src_wr[t] && $urandom_range(99) < gate_pct) begin
            wd                 = src_mem[t][src_rd[t] % DEPTH];
            in_vld[t]          = 1'b1;
            in_last[t]         = wd[W];
            in_data[t*W +: W]  = wd[W-1:0];
         end else begin
            in_vld[t]          = 1'b0;
            in_last[t]         = 1'($urandom_range(1));
            in_data[t*W +: W]  = $urandom;
         end
      end
      out_rdy = (rdy_mode == 2) ? ($urandom_range(3) != 0) : (rdy_mode == 1);
      tag_en  = cur_en;
      #1;
      room    = (exp_q.size() == 0) || out_rdy;
      exp_rdy = '0;
      if (m_lock && room) exp_rdy[m_grant] = 1'b1;
      chk("in_rdy", 64'(in_rdy), 64'(exp_rdy));
      chk("out_vld", 64'(out_vld), 64'(exp_q.size() != 0));
      if (exp_q.size() != 0) chk("out_word", 64'({out_last, out_tag, out_data}), 64'(exp_q[0]));
      chk("done_vld", 64'(done_vld), 64'(e_dv));
      if (e_dv) begin
         chk("done_tag", 64'(done_tag), 64'(e_dt));
         chk("done_err", 64'(done_err), 64'(e_de));
      end
      if (done_vld) done_log.push_back(done_tag);
      if (done_vld && done_err) begin
         wdog_step = step_no;
         wdog_tag  = done_tag;
      end
      if (out_vld && out_rdy) acc_cnt[out_tag]++;

      pop  = m_lock && room && in_vld[m_grant];
      n_dv = 1'b0;
      n_de = 1'b0;
      n_dt = e_dt;
      if (exp_q.size() != 0 && out_rdy) begin
         ow = exp_q.pop_front();
         if (ow[W+TW]) begin
            n_dv = 1'b1;
            n_dt = ow[W+TW-1:W];
         end
      end
      if (pop) begin
         exp_q.push_back({in_last[m_grant], TW'(m_grant), in_data[m_grant*W +: W]});
         src_rd[m_grant]++;
         if (m_grant == 5) pop5_step = step_no;
      end
      if (!m_lock) begin
         req = cur_en & in_vld;
         if (req != '0) begin
            m_grant = rr_pick(req, m_rr);
            m_lock  = 1'b1;
            m_stall = 0;
         end
      end else if (pop && in_last[m_grant]) begin
         m_rr   = (m_grant + 1) % N;
         m_lock = 1'b0;
      end
`ifdef APB2AXI_DRAIN_WDOG_EN
      else if (pop) begin
         m_stall = 0;
      end else if (!in_vld[m_grant]) begin
         m_stall++;
         if (m_stall >= WD && !n_dv) begin
            n_dv   = 1'b1;
            n_de   = 1'b1;
            n_dt   = TW'(m_grant);
            m_rr   = (m_grant + 1) % N;
            m_lock = 1'b0;
         end
      end
`endif
      e_dv = n_dv;
      e_de = n_de;
      e_dt = n_dt;
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) step();
   endtask

   task automatic model_reset();
      for (int t = 0; t < N; t++) src_rd[t] = src_wr[t];
      in_vld = '0;
      exp_q.delete();
      e_dv    = 1'b0;
      e_de    = 1'b0;
      e_dt    = '0;
      m_lock  = 1'b0;
      m_rr    = 0;
      m_stall = 0;
   endtask

   task automatic reset_mid();
      #2;
      preset = 1'b1;
      #1;
      chk_zero("rst_mid");
      model_reset();
      @(negedge pclk);
      preset = 1'b0;
   endtask

   task automatic clear_logs();
      done_log.delete();
      for (int t = 0; t < N; t++) acc_cnt[t] = 0;
   endtask

   initial begin
      preset  = 1'b1;
      tag_en  = '0;
      in_vld  = '0;
      in_last = '0;
      in_data = '0;
      out_rdy = 1'b0;
      for (int t = 0; t < N; t++) begin
         src_wr[t]  = 0;
         src_rd[t]  = 0;
         acc_cnt[t] = 0;
      end
      @(negedge pclk);
      @(negedge pclk);
      #1;
      chk_zero("por");
      @(negedge pclk);
      preset = 1'b0;

      // Two 2-word bursts on tags 0 and 2, only those two enabled
      clear_logs();
      cur_en = 8'h05;
      add_burst(0, 2);
      add_burst(2, 2);
      run(10);
      chk("s1_ndone", 64'(done_log.size()), 64'(2));
      if (done_log.size() >= 2) begin
         chk("s1_done0", 64'(done_log[0]), 64'(0));
         chk("s1_done1", 64'(done_log[1]), 64'(2));
      end
      chk("s1_words0", 64'(acc_cnt[0]), 64'(2));
      chk("s1_words2", 64'(acc_cnt[2]), 64'(2));

      // Pointer now sits at 3: tag 3 must beat tag 1
      clear_logs();
      cur_en = '1;
      add_burst(1, 1);
      add_burst(3, 1);
      run(8);
      chk("s1b_ndone", 64'(done_log.size()), 64'(2));
      if (done_log.size() >= 2) begin
         chk("s1b_first", 64'(done_log[0]), 64'(3));
         chk("s1b_second", 64'(done_log[1]), 64'(1));
      end

      // Backpressure mid-burst on tag 3
      clear_logs();
      add_burst(3, 6);
      rdy_mode = 1;
      run(3);
      rdy_mode = 0;
      run(5);
      rdy_mode = 1;
      run(10);
      chk("s2_words3", 64'(acc_cnt[3]), 64'(6));
      chk("s2_ndone", 64'(done_log.size()), 64'(1));

      // Move the pointer to 7, then race tags 7 and 1
      add_burst(6, 1);
      run(6);
      clear_logs();
      add_burst(7, 2);
      add_burst(1, 2);
      run(12);
      chk("s3_ndone", 64'(done_log.size()), 64'(2));
      if (done_log.size() >= 2) begin
         chk("s3_first", 64'(done_log[0]), 64'(7));
         chk("s3_second", 64'(done_log[1]), 64'(1));
      end

      // Disable the granted tag after its first word
      clear_logs();
      cur_en = 8'h10;
      add_burst(4, 4);
      run(2);
      cur_en = '0;
      run(8);
      chk("s4_words4", 64'(acc_cnt[4]), 64'(4));
      chk("s4_ndone", 64'(done_log.size()), 64'(1));
      if (done_log.size() >= 1) chk("s4_done_tag", 64'(done_log[0]), 64'(4));

      // Asynchronous reset in the middle of a burst
      cur_en = '1;
      add_burst(6, 8);
      run(4);
      reset_mid();
      clear_logs();
      add_burst(5, 1);
      add_burst(2, 1);
      run(10);
      chk("s5_ndone", 64'(done_log.size()), 64'(2));
      if (done_log.size() >= 2) begin
         chk("s5_first", 64'(done_log[0]), 64'(2));
         chk("s5_second", 64'(done_log[1]), 64'(5));
      end

      // Random traffic
      gate_pct = 80;
      rdy_mode = 2;
      for (int c = 0; c < 3000; c++) begin
         int t;
         if (c % 50 == 0) cur_en = N'($urandom);
         if ($urandom_range(9) == 0) begin
            t = $urandom_range(N - 1);
            if (src_wr[t] - src_rd[t] < 8) add_burst(t, $urandom_range(4, 1));
         end
         step();
      end
      gate_pct = 100;
      rdy_mode = 1;
      cur_en   = '1;
      run(150);
      for (int t = 0; t < N; t++) chk("drained", 64'(src_wr[t] - src_rd[t]), 64'(0));
      chk("out_empty", 64'(out_vld), 64'(0));

`ifdef APB2AXI_DRAIN_WDOG_EN
      // Tag 5 sends one non-last word and then goes silent
      clear_logs();
      pop5_step = -1;
      wdog_step = -1;
      add_word(5, 1'b0);
      run(30);
      chk("wdog_seen", 64'(wdog_step >= 0), 64'(1));
      chk("wdog_lat", 64'(wdog_step - pop5_step), 64'(WD + 1));
      chk("wdog_tag", 64'(wdog_tag), 64'(5));
      clear_logs();
      add_burst(1, 1);
      run(8);
      chk("wdog_after", 64'(acc_cnt[1]), 64'(1));
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
`default_nettype wire
